// File: rtl/data_mem_pkg.sv
// Shared types and encodings for the MEM-stage data memory responder.
// Optional build switch: DATA_MEM_SIGNED_BYTE_EN (sign-extending byte loads).
package data_mem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 256;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic RW_LOAD   = 1'b0;
  localparam logic RW_STORE  = 1'b1;

  typedef enum logic {
    IDLE,
    SPLIT
  } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the EX_MEM pipeline register and the data memory.
// Sign_enable exists only when DATA_MEM_SIGNED_BYTE_EN is defined.
interface data_mem_responder_if
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              Enable_signal;
  logic              RW_enable;
  logic              Size_enable;
  logic              load_instr;
`ifdef DATA_MEM_SIGNED_BYTE_EN
  logic              Sign_enable;
`endif
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              done;
  logic              stall;

`ifdef DATA_MEM_SIGNED_BYTE_EN
  modport master (
    output Enable_signal, RW_enable, Size_enable, load_instr, Sign_enable, address, data_in,
    input  data_out, done, stall
  );
  modport slave (
    input  Enable_signal, RW_enable, Size_enable, load_instr, Sign_enable, address, data_in,
    output data_out, done, stall
  );
`else
  modport master (
    output Enable_signal, RW_enable, Size_enable, load_instr, address, data_in,
    input  data_out, done, stall
  );
  modport slave (
    input  Enable_signal, RW_enable, Size_enable, load_instr, address, data_in,
    output data_out, done, stall
  );
`endif

endinterface

// File: rtl/dm_lane_select.sv
// Picks which bytes of a big-endian word take part in the current phase.
// Lane k is word byte k (lane 0 = most significant byte, stored at the base address).
module dm_lane_select
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                   [ADDR_W-1:0] address,
  input  logic                                size_enable,
  input  logic                                phase,
  output logic [3:0]                          lane_en,
  output logic [3:0]             [ADDR_W-1:0] lane_idx
);

  // Phase 0 covers the bytes up to the end of the aligned word, phase 1 the rest.
  always_comb begin
    lane_en  = '0;
    lane_idx = '0;
    for (int k = 0; k < 4; k++) begin
      lane_idx[k] = address + ADDR_W'(k);
      if (size_enable == SIZE_WORD) begin
        if (phase)
          lane_en[k] = (int'(address[1:0]) + k) > 3;
        else
          lane_en[k] = (int'(address[1:0]) + k) <= 3;
      end
    end
    if (size_enable == SIZE_BYTE)
      lane_en[0] = !phase;
  end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage byte-addressed big-endian data memory; misaligned words take two edges.
// Define DATA_MEM_SIGNED_BYTE_EN to add Sign_enable for sign-extended byte loads.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input logic                 clk,
  input logic                 R,
  data_mem_responder_if.slave bus
);

  logic [7:0] Mem [0:DEPTH-1];

  state_t                  state;
  logic                    rw_q;
  logic [31:0]             hold;
  logic [31:0]             data_q;
  logic                    done_q;

  logic                    phase;
  logic                    size_sel;
  logic [3:0]              lane_en;
  logic [3:0][ADDR_W-1:0]  lane_idx;
  logic [31:0]             lane_word;
  logic [31:0]             store_word;
  logic [31:0]             byte_result;
  logic                    is_store;
  logic                    is_load;
  logic                    misaligned;
  logic                    wr_active;

  assign phase    = (state == SPLIT);
  assign size_sel = phase ? SIZE_WORD : bus.Size_enable;

  dm_lane_select #(.ADDR_W(ADDR_W)) u_lane_select (
    .address     (bus.address),
    .size_enable (size_sel),
    .phase       (phase),
    .lane_en     (lane_en),
    .lane_idx    (lane_idx)
  );

  assign is_store   = bus.Enable_signal && (bus.RW_enable == RW_STORE);
  assign is_load    = bus.Enable_signal && (bus.RW_enable == RW_LOAD) && bus.load_instr;
  assign misaligned = (bus.Size_enable == SIZE_WORD) && (bus.address[1:0] != 2'b00);
  assign wr_active  = phase ? (rw_q == RW_STORE) : is_store;

  // A byte access always travels on lane 0, i.e. the top byte of the word buses.
  assign store_word = (size_sel == SIZE_WORD) ? bus.data_in : {bus.data_in[7:0], 24'h0};

  always_comb begin
    lane_word = '0;
    for (int k = 0; k < 4; k++)
      if (lane_en[k])
        lane_word[31-8*k -: 8] = Mem[lane_idx[k]];
  end

`ifdef DATA_MEM_SIGNED_BYTE_EN
  assign byte_result = bus.Sign_enable ? {{24{lane_word[31]}}, lane_word[31:24]}
                                       : {24'h0, lane_word[31:24]};
`else
  assign byte_result = {24'h0, lane_word[31:24]};
`endif

  // Storage has no reset so benches can preload it and contents survive a CPU reset.
  always_ff @(posedge clk) begin
    if (wr_active)
      for (int k = 0; k < 4; k++)
        if (lane_en[k])
          Mem[lane_idx[k]] <= store_word[31-8*k -: 8];
  end

  // Control FSM; SPLIT finishes with the direction captured at the first edge.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state  <= IDLE;
      rw_q   <= RW_LOAD;
      hold   <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (is_store || is_load) begin
            if (misaligned) begin
              state <= SPLIT;
              rw_q  <= bus.RW_enable;
              if (is_load)
                hold <= lane_word;
            end else begin
              done_q <= 1'b1;
              if (is_load)
                data_q <= (bus.Size_enable == SIZE_WORD) ? lane_word : byte_result;
            end
          end
        end
        SPLIT: begin
          state  <= IDLE;
          done_q <= 1'b1;
          if (rw_q == RW_LOAD)
            data_q <= hold | lane_word;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out = data_q;
  assign bus.done     = done_q;
  assign bus.stall    = R && (state == IDLE) && (is_store || is_load) && misaligned;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table, directed corner cases
// and randomized traffic against a byte-array memory model.
module tb_data_mem_responder;
  import data_mem_pkg::*;

  logic clk = 1'b0;
  logic R   = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDR_W(8)) bus ();

  data_mem_responder #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk (clk),
    .R   (R),
    .bus (bus)
  );

  typedef struct {
    logic        en;
    logic        rw;
    logic        sz;
    logic        li;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_done;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] model_mem [256];
  vec_t       vecs [11];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic sz, input logic [7:0] a, input logic sgn);
    logic [7:0] a1, a2, a3, b;
    a1 = a + 8'd1;
    a2 = a + 8'd2;
    a3 = a + 8'd3;
    b  = model_mem[a];
    if (sz) return {model_mem[a], model_mem[a1], model_mem[a2], model_mem[a3]};
`ifdef DATA_MEM_SIGNED_BYTE_EN
    if (sgn) return {{24{b[7]}}, b};
`else
    if (sgn) return {24'h0, b};
`endif
    return {24'h0, b};
  endfunction

  task automatic model_store(input logic sz, input logic [7:0] a, input logic [31:0] d);
    logic [7:0] idx;
    if (sz) begin
      for (int k = 0; k < 4; k++) begin
        idx = a + 8'(k);
        model_mem[idx] = d[31-8*k -: 8];
      end
    end else begin
      model_mem[a] = d[7:0];
    end
  endtask

  task automatic drive_req(input logic en, input logic rw, input logic sz, input logic li,
                           input logic [7:0] addr, input logic [31:0] din, input logic sgn);
    bus.Enable_signal = en;
    bus.RW_enable     = rw;
    bus.Size_enable   = sz;
    bus.load_instr    = li;
    bus.address       = addr;
    bus.data_in       = din;
`ifdef DATA_MEM_SIGNED_BYTE_EN
    bus.Sign_enable   = sgn;
`else
    if (sgn) bus.data_in = din;
`endif
  endtask

  task automatic idle_cycle();
    bus.Enable_signal = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Holds a request until done (at most four edges) and reports what was seen.
  task automatic access(input logic rw, input logic sz, input logic li, input logic [7:0] addr,
                        input logic [31:0] din, input logic sgn,
                        output int stall_cyc, output int edges, output logic done_seen,
                        output logic [31:0] dout);
    drive_req(1'b1, rw, sz, li, addr, din, sgn);
    #1;
    stall_cyc = 0;
    edges     = 0;
    done_seen = 1'b0;
    while (!done_seen && edges < 4) begin
      if (bus.stall) stall_cyc++;
      @(posedge clk);
      #1;
      edges++;
      done_seen = bus.done;
    end
    dout = bus.data_out;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive_req(v.en, v.rw, v.sz, v.li, v.addr, v.din, 1'b0);
    if (v.en && v.rw) model_store(v.sz, v.addr, v.din);
    @(posedge clk);
    #1;
  endtask

  task automatic checked_access(input string name, input logic rw, input logic sz, input logic li,
                                input logic [7:0] addr, input logic [31:0] din, input logic sgn,
                                input logic [31:0] exp_dout);
    int          sc, ed;
    logic        dn;
    logic [31:0] dv;
    logic        mis;
    mis = sz && (addr[1:0] != 2'b00);
    access(rw, sz, li, addr, din, sgn, sc, ed, dn, dv);
    checkOutput({name, " done"}, {31'h0, dn}, 32'h1);
    checkOutput({name, " stall cycles"}, sc, mis ? 32'd1 : 32'd0);
    checkOutput({name, " latency"}, ed, mis ? 32'd2 : 32'd1);
    checkOutput({name, " data_out"}, dv, exp_dout);
    if (rw) model_store(sz, addr, din);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] exp_dout;
    logic [31:0] exp_val;
    logic [7:0]  old5, old10, old4, old5b;

    // Reset asserted mid-cycle with a misaligned load pending.
    drive_req(1'b1, RW_LOAD, SIZE_WORD, 1'b1, 8'h05, 32'h0, 1'b0);
    #2 R = 1'b0;
    #1;
    checkOutput("reset data_out", bus.data_out, 32'h0);
    checkOutput("reset done", {31'h0, bus.done}, 32'h0);
    checkOutput("reset stall", {31'h0, bus.stall}, 32'h0);
    @(posedge clk);
    #1;
    bus.Enable_signal = 1'b0;
    #5 R = 1'b1;
    idle_cycle();

    for (int i = 0; i < 64; i++) begin
      int sc, ed; logic dn; logic [31:0] dv; logic [31:0] d;
      d = $urandom;
      access(RW_STORE, SIZE_WORD, 1'b0, 8'(4*i), d, 1'b0, sc, ed, dn, dv);
      model_store(SIZE_WORD, 8'(4*i), d);
      if (i % 16 == 0) checkOutput("fill done", {31'h0, dn}, 32'h1);
    end

    // Back-to-back aligned traffic, one request per cycle.
    vecs[0]  = '{1'b1, RW_STORE, SIZE_WORD, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0,        1'b1};
    vecs[1]  = '{1'b1, RW_LOAD,  SIZE_WORD, 1'b1, 8'h10, 32'h0,        32'hDEADBEEF, 1'b1};
    vecs[2]  = '{1'b1, RW_LOAD,  SIZE_BYTE, 1'b1, 8'h11, 32'h0,        32'h000000AD, 1'b1};
    vecs[3]  = '{1'b1, RW_STORE, SIZE_BYTE, 1'b0, 8'h21, 32'h1234569C, 32'h000000AD, 1'b1};
    vecs[4]  = '{1'b1, RW_LOAD,  SIZE_BYTE, 1'b1, 8'h21, 32'h0,        32'h0000009C, 1'b1};
    vecs[5]  = '{1'b1, RW_LOAD,  SIZE_WORD, 1'b0, 8'h10, 32'h0,        32'h0000009C, 1'b0};
    vecs[6]  = '{1'b0, RW_STORE, SIZE_WORD, 1'b0, 8'h10, 32'h55555555, 32'h0000009C, 1'b0};
    vecs[7]  = '{1'b1, RW_STORE, SIZE_WORD, 1'b0, 8'h10, 32'h01020304, 32'h0000009C, 1'b1};
    vecs[8]  = '{1'b1, RW_LOAD,  SIZE_WORD, 1'b1, 8'h10, 32'h0,        32'h01020304, 1'b1};
    vecs[9]  = '{1'b1, RW_LOAD,  SIZE_BYTE, 1'b1, 8'h13, 32'h0,        32'h00000004, 1'b1};
    vecs[10] = '{1'b1, RW_LOAD,  SIZE_BYTE, 1'b1, 8'h10, 32'h0,        32'h00000001, 1'b1};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d done", i), {31'h0, bus.done}, {31'h0, vecs[i].exp_done});
      checkOutput($sformatf("vec%0d data_out", i), bus.data_out, vecs[i].exp_dout);
    end
    idle_cycle();
    checkOutput("idle done", {31'h0, bus.done}, 32'h0);
    checkOutput("idle data_out hold", bus.data_out, 32'h00000001);

    // Misaligned store straddling two aligned words.
    old5  = model_mem[8'h05];
    old10 = model_mem[8'h0A];
    checked_access("mis store", RW_STORE, SIZE_WORD, 1'b0, 8'h06, 32'h11223344, 1'b0, 32'h00000001);
    checked_access("rd 5",  RW_LOAD, SIZE_BYTE, 1'b1, 8'h05, 32'h0, 1'b0, {24'h0, old5});
    checked_access("rd 6",  RW_LOAD, SIZE_BYTE, 1'b1, 8'h06, 32'h0, 1'b0, 32'h11);
    checked_access("rd 7",  RW_LOAD, SIZE_BYTE, 1'b1, 8'h07, 32'h0, 1'b0, 32'h22);
    checked_access("rd 8",  RW_LOAD, SIZE_BYTE, 1'b1, 8'h08, 32'h0, 1'b0, 32'h33);
    checked_access("rd 9",  RW_LOAD, SIZE_BYTE, 1'b1, 8'h09, 32'h0, 1'b0, 32'h44);
    checked_access("rd 10", RW_LOAD, SIZE_BYTE, 1'b1, 8'h0A, 32'h0, 1'b0, {24'h0, old10});
    checked_access("rd mis word", RW_LOAD, SIZE_WORD, 1'b1, 8'h07, 32'h0, 1'b0,
                   {8'h22, 8'h33, 8'h44, old10});

    // Word load wrapping past the top of memory.
    checked_access("st FE", RW_STORE, SIZE_BYTE, 1'b0, 8'hFE, 32'hA1, 1'b0, {8'h22, 8'h33, 8'h44, old10});
    checked_access("st FF", RW_STORE, SIZE_BYTE, 1'b0, 8'hFF, 32'hB2, 1'b0, {8'h22, 8'h33, 8'h44, old10});
    checked_access("st 00", RW_STORE, SIZE_BYTE, 1'b0, 8'h00, 32'hC3, 1'b0, {8'h22, 8'h33, 8'h44, old10});
    checked_access("st 01", RW_STORE, SIZE_BYTE, 1'b0, 8'h01, 32'hD4, 1'b0, {8'h22, 8'h33, 8'h44, old10});
    checked_access("wrap load", RW_LOAD, SIZE_WORD, 1'b1, 8'hFE, 32'h0, 1'b0, 32'hA1B2C3D4);

    // Reset while the second half of a misaligned store is pending.
    old4  = model_mem[8'h04];
    old5b = model_mem[8'h05];
    drive_req(1'b1, RW_STORE, SIZE_WORD, 1'b0, 8'h02, 32'hCAFEF00D, 1'b0);
    #1;
    checkOutput("split rst stall idle", {31'h0, bus.stall}, 32'h1);
    @(posedge clk);
    #1;
    checkOutput("split rst stall split", {31'h0, bus.stall}, 32'h0);
    checkOutput("split rst done split", {31'h0, bus.done}, 32'h0);
    #2 R = 1'b0;
    #1;
    checkOutput("split rst data_out", bus.data_out, 32'h0);
    checkOutput("split rst done", {31'h0, bus.done}, 32'h0);
    checkOutput("split rst stall", {31'h0, bus.stall}, 32'h0);
    bus.Enable_signal = 1'b0;
    #1 R = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("split rst no done", {31'h0, bus.done}, 32'h0);
    model_mem[8'h02] = 8'hCA;
    model_mem[8'h03] = 8'hFE;
    checked_access("rd 2", RW_LOAD, SIZE_BYTE, 1'b1, 8'h02, 32'h0, 1'b0, 32'hCA);
    checked_access("rd 3", RW_LOAD, SIZE_BYTE, 1'b1, 8'h03, 32'h0, 1'b0, 32'hFE);
    checked_access("rd 4", RW_LOAD, SIZE_BYTE, 1'b1, 8'h04, 32'h0, 1'b0, {24'h0, old4});
    checked_access("rd 5b", RW_LOAD, SIZE_BYTE, 1'b1, 8'h05, 32'h0, 1'b0, {24'h0, old5b});

    // Reset clears a live done pulse and a pending stall at once.
    exp_val = model_load(SIZE_WORD, 8'h10, 1'b0);
    checked_access("pre rst load", RW_LOAD, SIZE_WORD, 1'b1, 8'h10, 32'h0, 1'b0, exp_val);
    drive_req(1'b1, RW_LOAD, SIZE_WORD, 1'b1, 8'h05, 32'h0, 1'b0);
    #1;
    checkOutput("pend stall", {31'h0, bus.stall}, 32'h1);
    #1 R = 1'b0;
    #1;
    checkOutput("async rst stall", {31'h0, bus.stall}, 32'h0);
    checkOutput("async rst done", {31'h0, bus.done}, 32'h0);
    checkOutput("async rst data_out", bus.data_out, 32'h0);
    bus.Enable_signal = 1'b0;
    #1 R = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post rst done", {31'h0, bus.done}, 32'h0);

`ifdef DATA_MEM_SIGNED_BYTE_EN
    checked_access("byte signed", RW_LOAD, SIZE_BYTE, 1'b1, 8'h21, 32'h0, 1'b1, 32'hFFFFFF9C);
    checked_access("byte unsigned", RW_LOAD, SIZE_BYTE, 1'b1, 8'h21, 32'h0, 1'b0, 32'h0000009C);
`else
    checked_access("byte zero ext", RW_LOAD, SIZE_BYTE, 1'b1, 8'h21, 32'h0, 1'b0, 32'h0000009C);
`endif

    // Randomized traffic against the byte-array model.
    exp_dout = model_load(SIZE_WORD, 8'h10, 1'b0);
    checked_access("rand seed load", RW_LOAD, SIZE_WORD, 1'b1, 8'h10, 32'h0, 1'b0, exp_dout);
    for (int i = 0; i < 300; i++) begin
      logic rw, sz, li, sgn;
      logic [7:0] addr;
      logic [31:0] din;
      rw   = 1'($urandom_range(0, 1));
      sz   = 1'($urandom_range(0, 1));
      li   = ($urandom_range(0, 7) != 0);
      sgn  = 1'($urandom_range(0, 1));
      addr = 8'($urandom_range(0, 255));
      din  = $urandom;
      if (!rw && !li) begin
        drive_req(1'b1, RW_LOAD, sz, 1'b0, addr, din, sgn);
        #1;
        checkOutput("rand noop stall", {31'h0, bus.stall}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rand noop done", {31'h0, bus.done}, 32'h0);
        checkOutput("rand noop data_out", bus.data_out, exp_dout);
      end else begin
        if (!rw) exp_dout = model_load(sz, addr, sgn);
        checked_access($sformatf("rand%0d", i), rw, sz, li, addr, din, sgn, exp_dout);
      end
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    idle_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder at the MEM stage of the pipelined CPU; answers load/store requests issued from the EX_MEM pipeline register (Enable_signal, RW_enable, Size_enable, load_instr).
- Byte-addressed, big-endian storage supporting byte and word accesses.
- Aligned accesses complete in a single cycle.
- Misaligned word accesses are split into two phases. During the extra cycle the block raises stall, which the hazard logic uses to drop LE and select the CU_mux NOP path (S).

Parameters:
- ADDR_W, 8, byte-address width.
- DEPTH, 256, number of bytes in Mem; must equal 2**ADDR_W.

Ports:
- clk, input, 1, rising-edge clock.
- R, input, 1, reset: asynchronous, active-low.
- Enable_signal, input, 1, request valid.
- RW_enable, input, 1, 1 = store, 0 = load.
- Size_enable, input, 1, 1 = word (32 bit), 0 = byte.
- load_instr, input, 1, load marker from MEM stage; a load is serviced only if load_instr=1.
- address, input, ADDR_W, byte address.
- data_in, input, 32, store data; byte stores use data_in[7:0].
- data_out, output, 32, registered load result.
- done, output, 1, one-cycle pulse: access completed on the previous edge.
- stall, output, 1, combinational; requester must hold all inputs stable while it is 1.

Behaviour:
- Storage
  - Array Mem[0:DEPTH-1] of 8-bit bytes, preloadable hierarchically by benches.
  - Mem is not cleared by reset.
- Endianness
  - Word at address a = {Mem[a], Mem[a+1], Mem[a+2], Mem[a+3]}.
  - Byte index arithmetic is modulo DEPTH (wraps 255 -> 0).
- Reset (R=0, async)
  - State=IDLE; data_out=0; done=0; holding register=0.
  - stall forced 0 while R=0.
- States: IDLE, SPLIT.
- Request classification in IDLE (a request is Enable_signal=1)
  - Store: RW_enable=1.
  - Load: RW_enable=0 and load_instr=1.
  - RW_enable=0 and load_instr=0: no-op; no done pulse.
- Aligned access (byte, or word with address[1:0]=00)
  - Serviced at the sampling edge.
  - Store writes Mem at that edge.
  - Load updates data_out at that edge: byte load yields {24'b0, Mem[a]}.
  - done=1 for the following cycle. stall stays 0.
  - Latency: 1 edge.
- Misaligned word (Size_enable=1, address[1:0]!=00), in IDLE
  - stall=1 combinationally.
  - Edge 1: handles bytes a .. (a | 3), the remainder of the aligned word. Store writes them; load captures them into the holding register at their final bit positions. State goes to SPLIT.
  - In SPLIT: stall=0; inputs are still held by the requester.
  - Edge 2: handles the remaining bytes up to a+3 (mod DEPTH). Load: data_out = merged word. State goes to IDLE; done=1 for the following cycle.
  - Latency: 2 edges.
- SPLIT ignores changes to Enable_signal and RW_enable; it completes using the values held from edge 1.
- Reset mid-SPLIT: returns to IDLE immediately. Bytes already written at edge 1 stay written; no done pulse.
- data_out holds its value except on load completion; stores and idle cycles do not change it.
- Back-to-back aligned requests: one per cycle, with no bubble.
- Store then load to the same address on consecutive edges returns the new data.

Optional Feature:
- Macro: DATA_MEM_SIGNED_BYTE_EN.
- Defined:
  - Adds input port Sign_enable (1 bit).
  - A byte load with Sign_enable=1 returns {{24{Mem[a][7]}}, Mem[a]}.
  - Sign_enable=0 zero-extends.
  - Sign_enable is ignored for word loads and for stores.
- Undefined: port is absent; byte loads always zero-extend.

Decomposition:
- Package data_mem_pkg:
  - State enum (IDLE, SPLIT).
  - SIZE_BYTE=1'b0, SIZE_WORD=1'b1, RW_LOAD=1'b0, RW_STORE=1'b1.
  - Default ADDR_W and DEPTH.
- One sub-module, dm_lane_select (combinational):
  - Inputs: address[1:0], Size_enable, phase.
  - Outputs: 4-bit byte-lane enable and per-lane Mem index. Used by both the store path and the load-merge path.

Test Plan:
- Reset: assert R=0 mid-cycle with Enable_signal=1 -> data_out=0, done=0, stall=0 asynchronously.
- Aligned word: store 0xDEADBEEF at 0x10, then load 0x10 -> Mem[0x10..0x13] = DE,AD,BE,EF; data_out=0xDEADBEEF one edge after the load; done pulses once per access.
- Byte load: Mem[0x21]=0x9C, byte load 0x21 -> data_out=0x0000009C. With DATA_MEM_SIGNED_BYTE_EN and Sign_enable=1 -> 0xFFFFFF9C.
- Misaligned store: word 0x11223344 at 0x06 -> stall=1 for exactly one cycle; Mem[6..9] = 11,22,33,44; done after the second edge; Mem[5] and Mem[10] unchanged.
- Wrap-around load: Mem[0xFE,0xFF,0x00,0x01] = A1,B2,C3,D4, word load 0xFE -> data_out=0xA1B2C3D4 after 2 edges.
- Reset during SPLIT of store 0xCAFEF00D at 0x02 -> Mem[2,3] = CA,FE written; Mem[4,5] unchanged; state returns to IDLE; no done pulse.
